vernam_uart_tx: RTL and testbench
=================================

Name: vernam_uart_tx

Overview:
Downstream consumer of the cipher datapath. It takes ciphertext bytes that the cipher PicoBlaze writes to an output port, buffers them in a small FIFO, and serialises them as UART 8N1 frames on a single tx line. It exposes a combinational status byte for the PicoBlaze input-port mux and a sticky interrupt that is set when the transmit queue drains.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit; minimum 2.
FIFO_DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
PORT_BIT, 4, one-hot port_id bit that selects this block for writes and status reads.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
port_id  input  8  PicoBlaze port address.
write_strobe  input  1  PicoBlaze write strobe.
read_strobe  input  1  PicoBlaze read strobe.
out_port  input  8  ciphertext byte from the PicoBlaze.
interrupt_ack  input  1  PicoBlaze interrupt acknowledge; clears irq.
status  output  8  combinational: {4'b0, overflow, busy, full, empty}.
irq  output  1  sticky "queue drained" interrupt.
tx  output  1  UART serial line; idles high.

Behaviour:
- Reset values after the first edge with reset=1: tx=1, state IDLE, FIFO empty (empty=1, full=0), busy=0, overflow=0, irq=0. Reset wins over every other event.
- Reset asserted mid-frame: the frame is truncated, tx=1 on the next edge, and queued bytes are discarded.
- Write accept: on an edge where write_strobe & port_id[PORT_BIT]. If the FIFO is not full, out_port is pushed.
- Write while full: the byte is dropped and overflow is set to 1, even if a pop happens on the same edge.
- Overflow clear: on an edge where read_strobe & port_id[PORT_BIT]; the status byte read during that cycle still shows overflow=1. If set and clear coincide, set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is 0..FIFO_DEPTH; a simultaneous push and pop leaves the count unchanged.
- full = (count==FIFO_DEPTH); empty = (count==0).
- busy = (state != IDLE).
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is not empty, pop the head into shift_reg, go to START, and drive tx=0 at that edge. The first tx low therefore occurs one edge after the push edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift_reg[0] and bit_idx=0.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. After bit 7 go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go straight to START with tx=0 (no idle gap between frames). Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- irq:
  - Set on the edge where STOP completes with the FIFO empty and no push on that edge.
  - Cleared on an edge with interrupt_ack=1; ack has priority over set.
  - Not set by reset or by an empty FIFO that never transmitted.
- status is purely combinational from registered state, with no added latency, so it is valid in the same cycle as read_strobe.
- tx is driven directly from a register (glitch-free).

Test Plan:
1. Reset, then write 0xA5 with CLKS_PER_BIT=4 -> tx falls 1 cycle after the write edge; the line then reads 0 (start), 1,0,1,0,0,1,0,1 (LSB first), then 1 (stop), each level 4 cycles; busy=1 for 40 cycles; irq=1 after the stop bit; interrupt_ack -> irq=0 on the next edge.
2. Back-to-back: write 0x00 and 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit; irq is set only after the second frame.
3. Overflow: FIFO_DEPTH=4; write 6 bytes in consecutive cycles while the first frame is transmitting -> first byte popped, 4 queued, 1 dropped; status shows full=1 and overflow=1; 5 frames are transmitted in order; a status read clears overflow on the next edge.
4. Reset mid-frame: assert reset during DATA bit 3 -> tx=1 on the next edge, status=0x01, irq=0; no further frames are sent from the queue that existed before reset.
5. Wrap-around: FIFO_DEPTH=4; stream 10 bytes, keeping the FIFO partially filled -> every byte is transmitted in order across pointer wrap, and overflow stays 0.
6. Port decode: write with port_id[PORT_BIT]=0 (for example 0x08) -> no push and tx stays 1; interrupt_ack and an irq set on the same edge -> irq=0.

Source files
------------

// File: rtl/vernam_uart_tx_if.sv
// PicoBlaze port bus as seen by the UART transmitter: write/read strobes, data, status and interrupt.
interface vernam_uart_tx_if;
   logic [7:0] port_id;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] out_port;
   logic       interrupt_ack;
   logic [7:0] status;
   logic       irq;

   modport master (
      output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
      input  status, irq
   );

   modport slave (
      input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
      output status, irq
   );
endinterface

// File: rtl/vernam_uart_tx.sv
// Buffers ciphertext bytes written by the cipher PicoBlaze in a small FIFO and
// serialises them as back-to-back UART 8N1 frames on tx.
module vernam_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned PORT_BIT     = 4
) (
   input  logic            clk,
   input  logic            reset,
   vernam_uart_tx_if.slave bus,
   output logic            tx
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [2:0]    SEL_BIT    = 3'(PORT_BIT);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            overflow;
   logic            irq_q;

   logic            wr_sel;
   logic            rd_sel;
   logic            full;
   logic            empty;
   logic            busy;
   logic            push;
   logic            pop;
   logic            baud_done;
   logic            stop_done;
   logic            unused_port_bits;

   assign unused_port_bits = ^bus.port_id;

   assign wr_sel    = bus.write_strobe & bus.port_id[SEL_BIT];
   assign rd_sel    = bus.read_strobe  & bus.port_id[SEL_BIT];
   assign full      = (count == COUNT_FULL);
   assign empty     = (count == '0);
   assign busy      = (state != IDLE);
   assign baud_done = (baud_cnt == BAUD_LAST);
   assign stop_done = (state == STOP) && baud_done;

   // A full FIFO refuses the write even when the transmitter pops on the same edge.
   assign push = wr_sel & ~full;
   assign pop  = ~empty & ((state == IDLE) | stop_done);

   assign bus.status = {4'b0000, overflow, busy, full, empty};
   assign bus.irq    = irq_q;

   // FIFO storage
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= bus.out_port;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: a dropped write beats a simultaneous status read.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (wr_sel && full) begin
         overflow <= 1'b1;
      end else if (rd_sel) begin
         overflow <= 1'b0;
      end
   end

   // Queue-drained interrupt; acknowledge beats a same-edge set.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else if (bus.interrupt_ack) begin
         irq_q <= 1'b0;
      end else if (stop_done && empty && !push) begin
         irq_q <= 1'b1;
      end
   end

   // Frame sequencer; tx is registered so the line never glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (pop) begin
                  shift_reg <= mem[rd_ptr];
                  state     <= START;
                  tx        <= 1'b0;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx       <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg <= mem[rd_ptr];
                     state     <= START;
                     tx        <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vernam_uart_tx.sv
// Self-checking bench for vernam_uart_tx: a queue-based line model checked every cycle,
// a frame decoder on tx, directed scenarios with literal expectations, then random traffic.
module tb_vernam_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PBIT  = 4;
   localparam logic [7:0]  SEL   = 8'h10;

   logic clk;
   logic reset;
   logic tx;

   vernam_uart_tx_if bus ();

   vernam_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .PORT_BIT    (PBIT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave),
      .tx   (tx)
   );

   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: byte queue plus a schedule of line levels still to be shown.
   logic [7:0] mq[$];
   bit         lvl_q[$];
   bit         m_tx, m_busy, m_ovf, m_irq;
   bit         m_valid = 1'b0;
   bit         m_wr, m_rd, m_was_busy, m_pushed, m_lv;
   int         m_size_pre;
   logic [7:0] m_byte;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         lvl_q.delete();
         m_tx    = 1'b1;
         m_busy  = 1'b0;
         m_ovf   = 1'b0;
         m_irq   = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_wr       = bus.write_strobe && bus.port_id[PBIT];
         m_rd       = bus.read_strobe && bus.port_id[PBIT];
         m_size_pre = mq.size();
         m_was_busy = m_busy;
         if (lvl_q.size() == 0 && m_size_pre != 0) begin
            m_byte = mq.pop_front();
            for (int j = 0; j < 10; j++) begin
               m_lv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : m_byte[j-1];
               for (int c = 0; c < int'(CPB); c++) lvl_q.push_back(m_lv);
            end
         end
         if (lvl_q.size() != 0) begin
            m_tx   = lvl_q.pop_front();
            m_busy = 1'b1;
         end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
         end
         m_pushed = 1'b0;
         if (m_wr && m_size_pre == int'(DEPTH)) begin
            m_ovf = 1'b1;
         end else begin
            if (m_wr) begin
               mq.push_back(bus.out_port);
               m_pushed = 1'b1;
            end
            if (m_rd) m_ovf = 1'b0;
         end
         if (bus.interrupt_ack) m_irq = 1'b0;
         else if (m_was_busy && !m_busy && !m_pushed) m_irq = 1'b1;
      end
   end

   // Per-cycle compare against the model
   logic [7:0] exp_status;
   always @(negedge clk) begin
      if (m_valid) begin
         exp_status = {4'b0000, m_ovf, m_busy, mq.size() == int'(DEPTH), mq.size() == 0};
         check("cyc_tx", 32'(tx), 32'(m_tx));
         check("cyc_status", 32'(bus.status), 32'(exp_status));
         check("cyc_irq", 32'(bus.irq), 32'(m_irq));
      end
   end

   // Line decoder: samples each bit in its middle, LSB first.
   logic [7:0] rx_q[$];
   logic [7:0] rx_byte;
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid && !reset && tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (CPB) @(negedge clk);
               rx_byte[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            rx_q.push_back(rx_byte);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] pid, input logic [7:0] d);
      bus.port_id      = pid;
      bus.out_port     = d;
      bus.write_strobe = 1'b1;
      cyc();
      bus.write_strobe = 1'b0;
      bus.port_id      = 8'h00;
   endtask

   task automatic ack();
      bus.interrupt_ack = 1'b1;
      cyc();
      bus.interrupt_ack = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         if (bus.status[2:0] == 3'b001 && rx_idle_margin()) done = 1'b1;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s: transmitter still busy after %0d cycles", name, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   function automatic bit rx_idle_margin();
      return tx === 1'b1;
   endfunction

   logic [7:0] pat10;
   logic [9:0] a5_line;
   logic [7:0] t3[6];
   logic [7:0] sent[$];
   logic [7:0] d;

   initial begin
      reset             = 1'b1;
      bus.port_id       = 8'h00;
      bus.write_strobe  = 1'b0;
      bus.read_strobe   = 1'b0;
      bus.out_port      = 8'h00;
      bus.interrupt_ack = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_status", 32'(bus.status), 32'h01);
      check("rst_tx", 32'(tx), 32'h1);
      check("rst_irq", 32'(bus.irq), 32'h0);

      // Test 1: single 0xA5 frame, start,1,0,1,0,0,1,0,1,stop
      rx_q.delete();
      a5_line = 10'b1101001010;
      wr(SEL, 8'hA5);
      @(negedge clk);
      check("t1_tx_before_pop", 32'(tx), 32'h1);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         check("t1_line", 32'(tx), 32'(a5_line[k / 4]));
         check("t1_busy", 32'(bus.status[2]), 32'h1);
      end
      @(negedge clk);
      check("t1_idle_busy", 32'(bus.status[2]), 32'h0);
      check("t1_irq_set", 32'(bus.irq), 32'h1);
      check("t1_rx_count", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("t1_rx_byte", 32'(rx_q[0]), 32'hA5);
      ack();
      @(negedge clk);
      check("t1_irq_acked", 32'(bus.irq), 32'h0);

      // Test 2: back-to-back 0x00 then 0xFF, no idle gap
      rx_q.delete();
      bus.port_id      = SEL;
      bus.write_strobe = 1'b1;
      bus.out_port     = 8'h00;
      cyc();
      bus.out_port = 8'hFF;
      cyc();
      bus.write_strobe = 1'b0;
      bus.port_id      = 8'h00;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         check("t2_busy", 32'(bus.status[2]), 32'h1);
         if (k == 39) check("t2_stop1", 32'(tx), 32'h1);
         if (k == 40) check("t2_start2", 32'(tx), 32'h0);
         if (k == 79) check("t2_irq_late", 32'(bus.irq), 32'h0);
      end
      @(negedge clk);
      check("t2_done_busy", 32'(bus.status[2]), 32'h0);
      check("t2_irq_set", 32'(bus.irq), 32'h1);
      check("t2_rx_count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() > 1) begin
         check("t2_rx0", 32'(rx_q[0]), 32'h00);
         check("t2_rx1", 32'(rx_q[1]), 32'hFF);
      end
      ack();

      // Test 3: six writes into a depth-4 FIFO while the first frame is on the line
      rx_q.delete();
      for (int i = 0; i < 6; i++) t3[i] = 8'($urandom);
      bus.port_id      = SEL;
      bus.write_strobe = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.out_port = t3[i];
         cyc();
      end
      bus.write_strobe = 1'b0;
      bus.port_id      = 8'h00;
      @(negedge clk);
      check("t3_full_ovf", 32'(bus.status), 32'h0E);
      bus.port_id     = SEL;
      bus.read_strobe = 1'b1;
      #1;
      check("t3_read_cycle", 32'(bus.status), 32'h0E);
      cyc();
      bus.read_strobe = 1'b0;
      bus.port_id     = 8'h00;
      @(negedge clk);
      check("t3_ovf_cleared", 32'(bus.status), 32'h06);
      wait_idle("t3_drain", 400);
      check("t3_rx_count", 32'(rx_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < rx_q.size()) check("t3_rx_order", 32'(rx_q[i]), 32'(t3[i]));
      end

      // Test 4: reset during data bit 3 with a byte still queued (irq left set)
      bus.port_id      = SEL;
      bus.write_strobe = 1'b1;
      bus.out_port     = 8'($urandom);
      cyc();
      bus.out_port = 8'($urandom);
      cyc();
      bus.write_strobe = 1'b0;
      bus.port_id      = 8'h00;
      repeat (17) @(posedge clk);
      #1 reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("t4_tx", 32'(tx), 32'h1);
      check("t4_status", 32'(bus.status), 32'h01);
      check("t4_irq", 32'(bus.irq), 32'h0);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         check("t4_line_quiet", 32'(tx), 32'h1);
      end

      // Test 5: stream 10 bytes through the depth-4 FIFO across pointer wrap
      rx_q.delete();
      sent.delete();
      for (int n = 0; n < 10; n++) begin
         for (int g = 0; g < 1000 && mq.size() >= 3; g++) cyc();
         d = 8'($urandom);
         sent.push_back(d);
         wr(SEL, d);
         repeat ($urandom_range(0, 20)) cyc();
      end
      wait_idle("t5_drain", 800);
      check("t5_ovf", 32'(bus.status[3]), 32'h0);
      check("t5_rx_count", 32'(rx_q.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < rx_q.size()) check("t5_rx_order", 32'(rx_q[i]), 32'(sent[i]));
      end

      // Test 6: port decode, then acknowledge coinciding with the drain edge
      ack();
      wr(8'h08, 8'h3C);
      @(negedge clk);
      check("t6_no_push", 32'(bus.status), 32'h01);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("t6_tx_idle", 32'(tx), 32'h1);
      end
      wr(SEL, 8'h5A);
      repeat (40) @(posedge clk);
      #1 bus.interrupt_ack = 1'b1;
      cyc();
      bus.interrupt_ack = 1'b0;
      @(negedge clk);
      check("t6_ack_beats_set", 32'(bus.irq), 32'h0);
      check("t6_idle", 32'(bus.status), 32'h01);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         pat10 = 8'($urandom);
         bus.port_id       = ($urandom_range(0, 1) == 1) ? (pat10 | SEL) : (pat10 & ~SEL);
         bus.out_port      = 8'($urandom);
         bus.write_strobe  = ($urandom_range(0, 9) < 2);
         bus.read_strobe   = ($urandom_range(0, 19) == 0);
         bus.interrupt_ack = ($urandom_range(0, 29) == 0);
         reset             = ($urandom_range(0, 999) == 0);
         cyc();
      end
      bus.write_strobe  = 1'b0;
      bus.read_strobe   = 1'b0;
      bus.interrupt_ack = 1'b0;
      bus.port_id       = 8'h00;
      reset             = 1'b0;
      wait_idle("rand_drain", 400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
